ysyx_25060170_ctrl: RTL and testbench
=====================================

# ysyx_25060170_ctrl

Multicycle sequencing controller for the single-issue NPC core. It steps one instruction at a time through fetch, decode, execute, optional memory access and writeback, and gates the IFU, IDU, EXU, LSU and WBU with one-hot enables. It also provides a retired-instruction counter, a watchdog on fetch and memory waits, and sticky halt/error status for the simulation environment.

## Interface
Parameters:
- TIMEOUT, 255: maximum wait cycles in FETCH or MEM before an error is raised.
- CNT_W, 8: width of the watchdog counter; TIMEOUT must be below 2^CNT_W.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ifu_req  out  1  fetch request; held high for the whole FETCH state.
- ifu_valid  in  1  instruction word available this cycle.
- inst_load  in  1  decoded instruction is a load; sampled in DECODE.
- inst_store  in  1  decoded instruction is a store; sampled in DECODE.
- inst_ebreak  in  1  decoded instruction is ebreak; sampled in DECODE.
- inst_illegal  in  1  decode failed; sampled in DECODE.
- idu_latch  out  1  IDU captures the instruction and its operands.
- exu_en  out  1  EXU registers its result.
- lsu_req  out  1  memory request; held high for the whole MEM state.
- lsu_we  out  1  write strobe qualifier; equals the latched store flag while lsu_req=1, else 0.
- lsu_done  in  1  memory access completed this cycle.
- wbu_commit  out  1  qualifies the GPR write enable and the PC update for one cycle.
- halt  out  1  sticky; an ebreak was decoded.
- error  out  1  sticky; an illegal instruction was decoded or the watchdog expired.
- err_code  out  2  0 = none, 1 = illegal, 2 = fetch timeout, 3 = memory timeout.
- retire_cnt  out  32  count of committed instructions.
- state_o  out  3  current state, for debug.

## Operation
- Moore FSM. State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERROR=7.
- All enables decode from the state only: ifu_req in FETCH, idu_latch in DECODE, exu_en in EXEC, lsu_req in MEM, wbu_commit in WB. No enables are asserted in other states.
- IDLE → FETCH unconditionally.
- FETCH:
  - ifu_valid=1 → DECODE.
  - Otherwise, watchdog reaches TIMEOUT → ERROR, err_code=2.
- DECODE: latch the load, store, ebreak and illegal flags. Next state by priority:
  - inst_illegal → ERROR, err_code=1.
  - inst_ebreak → HALT.
  - Otherwise → EXEC.
- EXEC: latched load or store → MEM; otherwise → WB.
- MEM:
  - lsu_done=1 → WB.
  - Otherwise, watchdog reaches TIMEOUT → ERROR, err_code=3.
- WB: retire_cnt increments by 1, then → FETCH.
- HALT and ERROR are terminal until reset. All enables are 0 in these states. halt or error holds at 1.
- Watchdog:
  - Clears to 0 on every transition into FETCH or MEM.
  - Increments by 1 each cycle spent waiting in FETCH or MEM.
  - Expires when the count equals TIMEOUT while the awaited input is still 0.
- Decoded flags are latched at DECODE and held until the next DECODE.
- retire_cnt wraps modulo 2^32 with no saturation.

## Timing
- Reset values: state=IDLE, all enables 0, lsu_we=0, halt=0, error=0, err_code=0, retire_cnt=0, watchdog=0, latched flags 0.
- Reset asserted mid-instruction forces all of the above immediately, asynchronously. No commit occurs.
- The first ifu_req is high on the second rising edge after rst deasserts (IDLE occupies one cycle).
- Minimum latency, with ifu_valid and lsu_done high on the first cycle they are sampled:
  - ALU, branch and jump instructions: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Loads and stores: 5 cycles.
- Simultaneous events:
  - ifu_valid or lsu_done arriving in the same cycle as watchdog expiry: the valid input wins and no error is raised.
  - inst_illegal together with inst_ebreak: illegal wins.
- ifu_valid outside FETCH and lsu_done outside MEM are ignored.
- wbu_commit is high for exactly one cycle per retired instruction. retire_cnt shows the new value on the cycle after WB.

## Test plan
- ALU instruction, ifu_valid on the first FETCH cycle → state sequence 1,2,3,5,1. wbu_commit pulses once; retire_cnt goes 0→1 after 4 cycles.
- Store, with lsu_done after 3 MEM cycles → lsu_req high for 3 cycles with lsu_we=1, then WB. Total 7 cycles; retire_cnt increments by 1.
- ifu_valid held 0 with TIMEOUT=4 → ERROR entered after 4 wait cycles with err_code=2. Enables stay 0 afterwards; a later ifu_valid pulse is ignored.
- ifu_valid arriving on the exact expiry cycle → DECODE, error stays 0.
- DECODE with illegal=1 and ebreak=1 → ERROR, err_code=1, halt=0. A separate run with ebreak only → HALT with halt=1 and retire_cnt unchanged.
- rst pulled low during MEM → all outputs return to their reset values at once. After release, FETCH is entered after one IDLE cycle and retire_cnt=0.

Source files
------------

// File: rtl/ysyx_25060170_ctrl.sv
// ysyx_25060170_ctrl
//   Multicycle sequencing controller for the single-issue NPC core. Steps one
//   instruction at a time through FETCH, DECODE, EXEC, optional MEM and WB,
//   and gates the functional units with one-hot, state-decoded enables.
//   Also keeps a retired-instruction counter, a fetch/memory watchdog and
//   sticky halt/error status for the simulation environment.
//
// Parameters
//   TIMEOUT  maximum wait cycles in FETCH or MEM before an error is raised
//   CNT_W    watchdog counter width (TIMEOUT < 2**CNT_W)
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   ifu_req / ifu_valid      fetch request (FETCH) / instruction available
//   inst_load/store/ebreak/illegal  decode flags, sampled in DECODE
//   idu_latch, exu_en        IDU capture (DECODE), EXU result register (EXEC)
//   lsu_req / lsu_we / lsu_done  memory request (MEM), write qualifier, done
//   wbu_commit               GPR write / PC update qualifier (WB)
//   halt, error, err_code    sticky status (err_code: 1 illegal, 2 fetch
//                            timeout, 3 memory timeout)
//   retire_cnt               committed-instruction count, wraps mod 2**32
//   state_o                  current state for debug
module ysyx_25060170_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req,
  input  logic        ifu_valid,
  input  logic        inst_load,
  input  logic        inst_store,
  input  logic        inst_ebreak,
  input  logic        inst_illegal,
  output logic        idu_latch,
  output logic        exu_en,
  output logic        lsu_req,
  output logic        lsu_we,
  input  logic        lsu_done,
  output logic        wbu_commit,
  output logic        halt,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [31:0] retire_cnt,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT);

  state_t           state, next_state;
  logic [CNT_W-1:0] wd_cnt;
  logic             load_q, store_q;
  logic             set_halt, set_err;
  logic [1:0]       code_nxt;

  // Next-state and status-event decode
  always_comb begin
    next_state = state;
    set_halt   = 1'b0;
    set_err    = 1'b0;
    code_nxt   = 2'd0;
    case (state)
      S_IDLE:   next_state = S_FETCH;
      S_FETCH: begin
        // A valid arriving on the expiry cycle wins over the watchdog
        if (ifu_valid) begin
          next_state = S_DECODE;
        end else if (wd_cnt == WD_LIMIT) begin
          next_state = S_ERROR;
          set_err    = 1'b1;
          code_nxt   = 2'd2;
        end
      end
      S_DECODE: begin
        if (inst_illegal) begin
          next_state = S_ERROR;
          set_err    = 1'b1;
          code_nxt   = 2'd1;
        end else if (inst_ebreak) begin
          next_state = S_HALT;
          set_halt   = 1'b1;
        end else begin
          next_state = S_EXEC;
        end
      end
      S_EXEC:   next_state = (load_q || store_q) ? S_MEM : S_WB;
      S_MEM: begin
        if (lsu_done) begin
          next_state = S_WB;
        end else if (wd_cnt == WD_LIMIT) begin
          next_state = S_ERROR;
          set_err    = 1'b1;
          code_nxt   = 2'd3;
        end
      end
      S_WB:     next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      S_ERROR:  next_state = S_ERROR;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      wd_cnt     <= '0;
      load_q     <= 1'b0;
      store_q    <= 1'b0;
      halt       <= 1'b0;
      error      <= 1'b0;
      err_code   <= 2'd0;
      retire_cnt <= '0;
    end else begin
      state <= next_state;
      // Counting only while remaining in a wait state makes every entry
      // into FETCH or MEM start from zero.
      if ((state == S_FETCH || state == S_MEM) && next_state == state) begin
        wd_cnt <= wd_cnt + CNT_W'(1);
      end else begin
        wd_cnt <= '0;
      end
      // ebreak/illegal act directly on the DECODE transition and are kept
      // in halt/error, so only the memory-class flags need holding.
      if (state == S_DECODE) begin
        load_q  <= inst_load;
        store_q <= inst_store;
      end
      if (set_halt) begin
        halt <= 1'b1;
      end
      if (set_err) begin
        error    <= 1'b1;
        err_code <= code_nxt;
      end
      if (state == S_WB) begin
        retire_cnt <= retire_cnt + 32'd1;
      end
    end
  end

  assign ifu_req    = (state == S_FETCH);
  assign idu_latch  = (state == S_DECODE);
  assign exu_en     = (state == S_EXEC);
  assign lsu_req    = (state == S_MEM);
  assign lsu_we     = (state == S_MEM) && store_q;
  assign wbu_commit = (state == S_WB);
  assign state_o    = state;

endmodule

// File: tb/tb_ysyx_25060170_ctrl.sv
// Self-checking bench for ysyx_25060170_ctrl. Each instruction is described
// by its kind and its fetch / memory wait lengths; the expected per-cycle
// state trace and status are derived from those directly.
module tb_ysyx_25060170_ctrl;

  localparam int TO = 4;

  // Architectural state numbers
  localparam int IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3,
                 MEM = 4, WB = 5, HALTS = 6, ERRS = 7;

  // Instruction kinds
  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_EBREAK = 3,
                 K_ILL = 4, K_ILL_EB = 5;

  logic        clk, rst;
  logic        ifu_req, ifu_valid;
  logic        inst_load, inst_store, inst_ebreak, inst_illegal;
  logic        idu_latch, exu_en, lsu_req, lsu_we, lsu_done, wbu_commit;
  logic        halt, error;
  logic [1:0]  err_code;
  logic [31:0] retire_cnt;
  logic [2:0]  state_o;

  int          checks, errors;
  logic [31:0] exp_retire;
  logic        exp_halt, exp_error, exp_store;
  logic [1:0]  exp_code;
  int          term_st;

  ysyx_25060170_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_valid(ifu_valid),
    .inst_load(inst_load), .inst_store(inst_store),
    .inst_ebreak(inst_ebreak), .inst_illegal(inst_illegal),
    .idu_latch(idu_latch), .exu_en(exu_en),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_done(lsu_done),
    .wbu_commit(wbu_commit), .halt(halt), .error(error),
    .err_code(err_code), .retire_cnt(retire_cnt), .state_o(state_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Compare every output against what state st implies plus the tracked status
  task automatic check_out(input int st, input string tag);
    logic [44:0] obs, exp;
    logic [5:0]  en;
    logic [2:0]  st3;
    st3 = st[2:0];
    en  = {st == FETCH, st == DECODE, st == EXEC, st == MEM,
           (st == MEM) && exp_store, st == WB};
    obs = {state_o, ifu_req, idu_latch, exu_en, lsu_req, lsu_we, wbu_commit,
           halt, error, err_code, retire_cnt};
    exp = {st3, en, exp_halt, exp_error, exp_code, exp_retire};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check the current cycle, drive this cycle's inputs, advance one clock
  task automatic step(input int st, input string tag, input logic iv,
                      input logic ld, input logic sv, input logic eb,
                      input logic il, input logic dn);
    check_out(st, tag);
    ifu_valid    = iv;
    inst_load    = ld;
    inst_store   = sv;
    inst_ebreak  = eb;
    inst_illegal = il;
    lsu_done     = dn;
    @(negedge clk);
  endtask

  task automatic step_noise(input int st, input string tag);
    step(st, tag, rb(), rb(), rb(), rb(), rb(), rb());
  endtask

  // df / dm: cycles the awaited input stays low before it rises
  task automatic do_instr(input int kind, input int df, input int dm);
    logic ld, sv, eb, il;
    int   nf, nm;
    ld = (kind == K_LOAD);
    sv = (kind == K_STORE);
    eb = (kind == K_EBREAK) || (kind == K_ILL_EB);
    il = (kind == K_ILL) || (kind == K_ILL_EB);

    nf = (df <= TO) ? df + 1 : TO + 1;
    for (int i = 0; i < nf; i++)
      step(FETCH, "fetch", i == df, rb(), rb(), rb(), rb(), rb());
    if (df > TO) begin
      exp_error = 1'b1; exp_code = 2'd2; term_st = ERRS;
      return;
    end

    step(DECODE, "decode", rb(), ld, sv, eb, il, rb());
    exp_store = sv;
    if (il) begin
      exp_error = 1'b1; exp_code = 2'd1; term_st = ERRS;
      return;
    end
    if (eb) begin
      exp_halt = 1'b1; term_st = HALTS;
      return;
    end

    step_noise(EXEC, "exec");

    if (ld || sv) begin
      nm = (dm <= TO) ? dm + 1 : TO + 1;
      for (int i = 0; i < nm; i++)
        step(MEM, "mem", rb(), rb(), rb(), rb(), rb(), i == dm);
      if (dm > TO) begin
        exp_error = 1'b1; exp_code = 2'd3; term_st = ERRS;
        return;
      end
    end

    step_noise(WB, "wb");
    exp_retire = exp_retire + 32'd1;
    term_st = FETCH;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step_noise(term_st, "terminal");
  endtask

  // Called at a falling edge: reset lands mid-cycle, away from any clock edge
  task automatic do_reset(input string tag);
    #3 rst = 1'b0;
    exp_retire = '0; exp_halt = 1'b0; exp_error = 1'b0;
    exp_code = 2'd0; exp_store = 1'b0;
    #1 check_out(IDLE, tag);
    @(negedge clk);
    rst = 1'b1;
    step_noise(IDLE, "idle_after_reset");
    term_st = FETCH;
  endtask

  initial begin
    checks = 0; errors = 0;
    exp_retire = '0; exp_halt = 1'b0; exp_error = 1'b0;
    exp_code = 2'd0; exp_store = 1'b0; term_st = FETCH;
    rst = 1'b0; ifu_valid = 1'b0; inst_load = 1'b0; inst_store = 1'b0;
    inst_ebreak = 1'b0; inst_illegal = 1'b0; lsu_done = 1'b0;

    @(negedge clk);
    check_out(IDLE, "reset_state");
    rst = 1'b1;
    step_noise(IDLE, "idle");

    // Directed: ALU minimum latency, store with 3 MEM cycles, delayed load
    do_instr(K_ALU, 0, 0);
    do_instr(K_STORE, 0, 2);
    do_instr(K_LOAD, 1, 0);

    // Random non-faulting instruction stream
    repeat (40)
      do_instr($urandom_range(0, 2), $urandom_range(0, TO), $urandom_range(0, TO));

    // Valid input on the exact expiry cycle wins
    do_instr(K_ALU, TO, 0);
    do_instr(K_LOAD, 0, TO);
    do_instr(K_STORE, TO, TO);

    // Fetch timeout, then stray ifu_valid pulses are ignored
    do_instr(K_ALU, TO + 1, 0);
    hold(6);
    do_reset("reset_after_fetch_to");

    // Memory timeout
    do_instr(K_LOAD, 0, TO + 1);
    hold(4);
    do_reset("reset_after_mem_to");

    // Illegal together with ebreak: illegal wins
    do_instr(K_ILL_EB, 0, 0);
    hold(3);
    do_reset("reset_after_illegal");

    // ebreak alone: halt, retire count unchanged
    do_instr(K_ALU, 0, 0);
    do_instr(K_EBREAK, 1, 0);
    hold(3);
    do_reset("reset_after_halt");

    // Reset pulled low while a store waits in MEM
    do_instr(K_ALU, 0, 0);
    step(FETCH, "fetch", 1'b1, rb(), rb(), rb(), rb(), rb());
    step(DECODE, "decode", rb(), 1'b0, 1'b1, 1'b0, 1'b0, rb());
    exp_store = 1'b1;
    step_noise(EXEC, "exec");
    step(MEM, "mem", rb(), rb(), rb(), rb(), rb(), 1'b0);
    check_out(MEM, "mem_before_reset");
    do_reset("reset_mid_mem");
    do_instr(K_ALU, 0, 0);

    // Random mix including terminal outcomes
    repeat (30) begin
      do_instr($urandom_range(0, 5), $urandom_range(0, TO + 1),
               $urandom_range(0, TO + 1));
      if (term_st != FETCH) begin
        hold(2);
        do_reset("reset_random");
      end
    end
    check_out(term_st, "final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
